// File: rtl/uart_boot_loader_pkg.sv
// Shared configuration for the UART boot loader slice.
//   TRUE / FALSE  : single-bit logic constants
//   RST_ENABLE    : level of rst_p that resets the design
//   IMEM_ADDR_W   : default instruction-memory word-address width
package uart_boot_loader_pkg;
  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;
  localparam logic RST_ENABLE = 1'b1;
  localparam int   IMEM_ADDR_W = 14;
endpackage

// File: rtl/uart_boot_loader_rx_strobe_sync.sv
// Brings the receiver's byte-complete level into the clk domain and turns
// each rising edge into a single-cycle strobe.
//   clk      : system clock
//   rst_p    : synchronous active-high reset
//   async_in : level from the receiver timing domain
//   stb_out  : one-cycle pulse, 3 clk after async_in rises
module rx_strobe_sync
  import uart_boot_loader_pkg::*;
(
  input  logic clk,
  input  logic rst_p,
  input  logic async_in,
  output logic stb_out
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk) begin
    if (rst_p == RST_ENABLE) begin
      sync_p0 <= FALSE;
      sync_p1 <= FALSE;
      sync_p2 <= FALSE;
      stb_out <= FALSE;
    end else begin
      // two-flop synchroniser
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
      // edge history and registered strobe
      sync_p2 <= sync_p1;
      stb_out <= sync_p1 & ~sync_p2;
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed byte frame, packs it into
// little-endian 32-bit words, writes them to instruction memory and holds
// the CPU in reset until the load completes.
//   clk, rst_p      : clock, synchronous active-high reset
//   rx_done/rx_data : receiver byte-complete level and byte
//   load_req        : one-cycle pulse re-arming the loader from DONE/ERROR
//   imem_we/addr/wdata : one-cycle IMEM write port
//   cpu_rst         : CPU reset hold (low only in DONE)
//   load_done/load_err : outcome of the last load
//   words_loaded    : words written in current/last load
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int ADDR_W         = IMEM_ADDR_W,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int WL_W = ADDR_W + 1;

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]  state;
  logic [15:0] len_n;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [31:0] tmo_cnt;
  logic        byte_stb;
  logic        tmo_expired;
  logic [15:0] len_full;
  logic        len_over;
  logic        last_word;

  rx_strobe_sync u_rx_strobe_sync (
    .clk      (clk),
    .rst_p    (rst_p),
    .async_in (rx_done),
    .stb_out  (byte_stb)
  );

  assign imem_we     = (state == S_WRITE);
  assign cpu_rst     = (state != S_DONE);
  assign tmo_expired = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign len_full    = {rx_data, len_n[7:0]};
  assign len_over    = (32'(len_full) > (32'd1 << ADDR_W));
  assign last_word   = ((32'(words_loaded) + 32'd1) == 32'(len_n));

  always_ff @(posedge clk) begin
    if (rst_p == RST_ENABLE) begin
      state        <= S_LEN_LO;
      len_n        <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      tmo_cnt      <= '0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      load_done    <= FALSE;
      load_err     <= FALSE;
      words_loaded <= '0;
    end else begin
      case (state)
        S_LEN_LO: begin
          tmo_cnt <= '0;
          if (byte_stb) begin
            len_n[7:0] <= rx_data;
            state      <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (byte_stb) begin
            tmo_cnt <= '0;
            len_n   <= len_full;
            if (len_full == 16'd0) begin
              state     <= S_DONE;
              load_done <= TRUE;
            end else if (len_over) begin
              state    <= S_ERROR;
              load_err <= TRUE;
            end else begin
              state        <= S_DATA;
              byte_idx     <= '0;
              imem_addr    <= '0;
              words_loaded <= '0;
            end
          end else if (tmo_expired) begin
            state    <= S_ERROR;
            load_err <= TRUE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        S_DATA: begin
          if (byte_stb) begin
            tmo_cnt <= '0;
            if (byte_idx == 2'd3) begin
              imem_wdata <= {rx_data, word_buf};
              byte_idx   <= '0;
              state      <= S_WRITE;
            end else begin
              word_buf <= {rx_data, word_buf[23:8]};
              byte_idx <= byte_idx + 2'd1;
            end
          end else if (tmo_expired) begin
            state    <= S_ERROR;
            load_err <= TRUE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        S_WRITE: begin
          // imem_addr still holds this word's address during the write cycle
          words_loaded <= words_loaded + WL_W'(1);
          imem_addr    <= imem_addr + ADDR_W'(1);
          if (last_word) begin
            state     <= S_DONE;
            load_done <= TRUE;
            tmo_cnt   <= '0;
          end else if (byte_stb) begin
            // a byte landing here starts the next word rather than being lost
            word_buf <= {rx_data, word_buf[23:8]};
            byte_idx <= 2'd1;
            tmo_cnt  <= '0;
            state    <= S_DATA;
          end else if (tmo_expired) begin
            state    <= S_ERROR;
            load_err <= TRUE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
            state   <= S_DATA;
          end
        end

        S_DONE: begin
          tmo_cnt <= '0;
          if (load_req) begin
            state        <= S_LEN_LO;
            load_done    <= FALSE;
            words_loaded <= '0;
            imem_addr    <= '0;
          end
        end

        S_ERROR: begin
          tmo_cnt <= '0;
          if (load_req) begin
            state    <= S_LEN_LO;
            load_err <= FALSE;
          end
        end

        default: state <= S_LEN_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 100;

  logic              clk = 1'b0;
  logic              rst_p;
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              load_req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  checks    = 0;
  int  errors    = 0;
  int  write_cnt = 0;

  always #5 clk = ~clk;

  uart_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .rst_p        (rst_p),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .load_req     (load_req),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // Scoreboard: every IMEM write must match the next expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_t e;
      write_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h data=%08h (no write expected)", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL write addr=%0h data=%08h expected addr=%0h data=%08h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hi);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hi) @(negedge clk);
    rx_done = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (load_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout load_done=%b expected 1 within %0d cycles", name, load_done, budget);
    end
  endtask

  task automatic check_end(input string name, input int exp_writes, input int writes_before,
                           input logic [ADDR_W:0] exp_wl);
    checks++;
    if (write_cnt - writes_before !== exp_writes) begin
      errors++;
      $display("FAIL %s_writes got %0d expected %0d", name, write_cnt - writes_before, exp_writes);
    end
    checks++;
    if (cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL %s_cpu_rst got %b expected 0", name, cpu_rst);
    end
    checks++;
    if (words_loaded !== exp_wl) begin
      errors++;
      $display("FAIL %s_words_loaded got %0d expected %0d", name, words_loaded, exp_wl);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d expected 0 outstanding writes", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_p = 1'b1;
    repeat (3) @(negedge clk);
    rst_p = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_rst, imem_we, load_done, load_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags cpu_rst,we,done,err=%b expected 1000",
               {cpu_rst, imem_we, load_done, load_err});
    end
    checks++;
    if (imem_addr !== '0 || imem_wdata !== 32'h0 || words_loaded !== '0) begin
      errors++;
      $display("FAIL reset_regs addr=%0h wdata=%08h wl=%0d expected 0 0 0",
               imem_addr, imem_wdata, words_loaded);
    end
  endtask

  task automatic test_two_words();
    int wb = write_cnt;
    logic [7:0] bytes [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'h93, 8'h00, 8'h10, 8'h00};
    push_exp(0, 32'h0000_0013);
    push_exp(1, 32'h0010_0093);
    foreach (bytes[i]) send_byte(bytes[i], 6);
    wait_done("two_words", 50);
    check_end("two_words", 2, wb, 2);
  endtask

  task automatic test_zero_len();
    int wb;
    pulse_load_req();
    checks++;
    if (load_done !== 1'b0 || cpu_rst !== 1'b1 || words_loaded !== '0) begin
      errors++;
      $display("FAIL rearm done=%b cpu_rst=%b wl=%0d expected 0 1 0", load_done, cpu_rst, words_loaded);
    end
    wb = write_cnt;
    send_byte(8'h00, 6);
    send_byte(8'h00, 6);
    wait_done("zero_len", 50);
    check_end("zero_len", 0, wb, 0);
  endtask

  task automatic test_timeout();
    int wb;
    pulse_load_req();
    wb = write_cnt;
    send_byte(8'h01, 6);
    send_byte(8'h00, 6);
    send_byte(8'hAA, 6);
    repeat (TIMEOUT + 10) @(negedge clk);
    checks++;
    if (load_err !== 1'b1 || cpu_rst !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err err=%b cpu_rst=%b done=%b expected 1 1 0", load_err, cpu_rst, load_done);
    end
    checks++;
    if (write_cnt !== wb) begin
      errors++;
      $display("FAIL timeout_writes got %0d expected 0", write_cnt - wb);
    end
    // byte in ERROR is ignored
    send_byte(8'h55, 6);
    checks++;
    if (load_err !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky err=%b expected 1", load_err);
    end
    pulse_load_req();
    checks++;
    if (load_err !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL err_clear err=%b cpu_rst=%b expected 0 1", load_err, cpu_rst);
    end
  endtask

  task automatic test_overflow();
    int wb = write_cnt;
    send_byte(8'h11, 6);
    send_byte(8'h00, 6);
    checks++;
    if (load_err !== 1'b1 || cpu_rst !== 1'b1 || write_cnt !== wb) begin
      errors++;
      $display("FAIL overflow err=%b cpu_rst=%b writes=%0d expected 1 1 0",
               load_err, cpu_rst, write_cnt - wb);
    end
    pulse_load_req();
  endtask

  task automatic test_full_capacity();
    int wb = write_cnt;
    logic [31:0] w;
    send_byte(8'h10, 6);
    send_byte(8'h00, 6);
    for (int a = 0; a < 16; a++) begin
      w = 32'hA5000000 | (a * 32'h0001_0203);
      push_exp(ADDR_W'(a), w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 3);
    end
    wait_done("full", 50);
    check_end("full", 16, wb, 16);
    pulse_load_req();
  endtask

  task automatic test_long_strobe();
    int wb = write_cnt;
    logic [7:0] bytes [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    push_exp(0, 32'hDEAD_BEEF);
    foreach (bytes[i]) send_byte(bytes[i], 50);
    wait_done("long_stb", 50);
    check_end("long_stb", 1, wb, 1);
    // load_req while loading is ignored; here it re-arms from DONE
    pulse_load_req();
  endtask

  task automatic test_reset_mid_word();
    int wb = write_cnt;
    logic [7:0] part [4] = '{8'h01, 8'h00, 8'h11, 8'h22};
    logic [7:0] full [6] = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    foreach (part[i]) send_byte(part[i], 6);
    @(negedge clk);
    load_req = 1'b1;   // ignored outside DONE/ERROR
    @(negedge clk);
    load_req = 1'b0;
    rst_p = 1'b1;
    repeat (2) @(negedge clk);
    rst_p = 1'b0;
    checks++;
    if (cpu_rst !== 1'b1 || words_loaded !== '0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset cpu_rst=%b wl=%0d done=%b expected 1 0 0", cpu_rst, words_loaded, load_done);
    end
    push_exp(0, 32'h1122_3344);
    foreach (full[i]) send_byte(full[i], 6);
    wait_done("midreset", 50);
    check_end("midreset", 1, wb, 1);
  endtask

  initial begin
    rst_p    = 1'b1;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    load_req = 1'b0;
    test_reset();
    test_two_words();
    test_zero_len();
    test_timeout();
    test_overflow();
    test_full_capacity();
    test_long_strobe();
    test_reset_mid_word();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
